// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if: caller load bus and frame-stable outputs toward the 7-seg scan mux
interface display_scan_ctrl_if;
  logic [15:0] hexs_in;
  logic [3:0] points_in;
  logic [3:0] les_in;
  logic [3:0] blink_in;
  logic load;
  logic [15:0] Hexs;
  logic [3:0] Points;
  logic [3:0] LES;
  logic [1:0] Scan;
  logic frame_tick;
  modport master (output hexs_in, points_in, les_in, blink_in, load, input Hexs, Points, LES, Scan, frame_tick);
  modport slave (input hexs_in, points_in, les_in, blink_in, load, output Hexs, Points, LES, Scan, frame_tick);
endinterface

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: digit scan timing with frame-boundary double buffering, ghosting guard and blink
module display_scan_ctrl #(
  parameter int DWELL_CYCLES = 50000,
  parameter int GUARD_CYCLES = 2000,
  parameter int BLINK_FRAMES = 128
) (
  input logic clk,
  input logic rst,
  display_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(DWELL_CYCLES);
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [CW-1:0] cnt, cnt_n;
  logic [FW-1:0] frame_cnt, frame_cnt_n;
  logic [1:0] scan_n;
  logic [15:0] pend_hexs, hexs_n;
  logic [3:0] pend_points, pend_les, pend_blink, points_n, les_n, blink_n, les, blink;
  logic pend_valid, phase, phase_n, wrap, boundary, frame_last, guard;
  // next-state of counters and active buffers; the boundary prefers a same-cycle load over pending data
  always_comb begin
    wrap = cnt == CW'(DWELL_CYCLES - 1);
    boundary = wrap && bus.Scan == 2'd3;
    cnt_n = wrap ? '0 : cnt + 1'b1;
    scan_n = wrap ? bus.Scan + 2'd1 : bus.Scan;
    hexs_n = !boundary ? bus.Hexs : bus.load ? bus.hexs_in : pend_valid ? pend_hexs : bus.Hexs;
    points_n = !boundary ? bus.Points : bus.load ? bus.points_in : pend_valid ? pend_points : bus.Points;
    les_n = !boundary ? les : bus.load ? bus.les_in : pend_valid ? pend_les : les;
    blink_n = !boundary ? blink : bus.load ? bus.blink_in : pend_valid ? pend_blink : blink;
    frame_last = frame_cnt == FW'(BLINK_FRAMES - 1);
    frame_cnt_n = !boundary ? frame_cnt : frame_last ? '0 : frame_cnt + 1'b1;
    phase_n = phase ^ (boundary && frame_last);
    guard = GUARD_CYCLES != 0 && cnt_n < CW'(GUARD_CYCLES);
  end
  // state registers; LES is built from next-state values so it lines up with Scan and cnt
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      bus.Scan <= 2'd0;
      bus.Hexs <= 16'h0;
      bus.Points <= 4'h0;
      bus.LES <= 4'hF;
      bus.frame_tick <= 1'b0;
      les <= 4'hF;
      blink <= 4'h0;
      pend_hexs <= 16'h0;
      pend_points <= 4'h0;
      pend_les <= 4'h0;
      pend_blink <= 4'h0;
      pend_valid <= 1'b0;
      phase <= 1'b0;
      frame_cnt <= '0;
    end else begin
      cnt <= cnt_n;
      bus.Scan <= scan_n;
      bus.Hexs <= hexs_n;
      bus.Points <= points_n;
      bus.LES <= les_n | (phase_n ? blink_n : 4'h0) | {4{guard}};
      bus.frame_tick <= boundary;
      les <= les_n;
      blink <= blink_n;
      if (bus.load) begin
        pend_hexs <= bus.hexs_in;
        pend_points <= bus.points_in;
        pend_les <= bus.les_in;
        pend_blink <= bus.blink_in;
      end
      pend_valid <= boundary ? 1'b0 : bus.load | pend_valid;
      phase <= phase_n;
      frame_cnt <= frame_cnt_n;
    end
  end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed stimulus against a time-indexed model of the scan controller
module tb_display_scan_ctrl;
  localparam int D = 8, G = 2, BF = 2, FR = 4 * D;
  logic clk = 1'b0, rst = 1'b1;
  display_scan_ctrl_if bus();
  display_scan_ctrl #(.DWELL_CYCLES(D), .GUARD_CYCLES(G), .BLINK_FRAMES(BF)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int tests = 0, fails = 0, mt = 0;
  bit chk = 0, pv = 0;
  logic [15:0] ah, ph;
  logic [3:0] ap, al, ab, pp, pl, pb;
  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at t=%0d: got %h expected %h", n, mt, act, exp);
    end
  endtask
  task automatic step_model();
    if (rst) begin
      mt = 0; pv = 0; chk = 1;
      ah = 16'h0; ap = 4'h0; al = 4'hF; ab = 4'h0;
    end else begin
      if ((mt + 1) % FR == 0) begin
        if (bus.load) begin
          ah = bus.hexs_in; ap = bus.points_in; al = bus.les_in; ab = bus.blink_in;
        end else if (pv) begin
          ah = ph; ap = pp; al = pl; ab = pb;
        end
        pv = 0;
      end else if (bus.load) begin
        ph = bus.hexs_in; pp = bus.points_in; pl = bus.les_in; pb = bus.blink_in; pv = 1;
      end
      mt++;
    end
  endtask
  task automatic compare();
    int c, f;
    logic [3:0] e;
    c = mt % D;
    f = mt / FR;
    e = al | (((f / BF) % 2) == 1 ? ab : 4'h0) | (c < G ? 4'hF : 4'h0);
    check("scan", bus.Scan, (mt / D) % 4);
    check("hexs", bus.Hexs, ah);
    check("points", bus.Points, ap);
    check("les", bus.LES, e);
    check("frame_tick", bus.frame_tick, (mt != 0 && mt % FR == 0) ? 1 : 0);
  endtask
  task automatic cyc();
    @(posedge clk);
    step_model();
    @(negedge clk);
    if (chk) compare();
  endtask
  task automatic goto(int tt);
    while (mt < tt) cyc();
  endtask
  task automatic ld(logic [15:0] h, logic [3:0] p, logic [3:0] l, logic [3:0] b);
    bus.hexs_in = h; bus.points_in = p; bus.les_in = l; bus.blink_in = b; bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
  endtask
  initial begin
    bus.hexs_in = 16'h0; bus.points_in = 4'h0; bus.les_in = 4'h0; bus.blink_in = 4'h0; bus.load = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    check("rst_scan", bus.Scan, 0);
    check("rst_les", bus.LES, 4'hF);
    check("rst_hexs", bus.Hexs, 0);
    check("rst_tick", bus.frame_tick, 0);
    goto(8);
    check("scan1", bus.Scan, 1);
    ld(16'h1234, 4'b1010, 4'h0, 4'h0);
    check("hold_before_frame", bus.Hexs, 0);
    goto(31);
    check("hold_last_cycle", bus.Hexs, 0);
    goto(32);
    check("xfer_hexs", bus.Hexs, 16'h1234);
    check("xfer_points", bus.Points, 4'b1010);
    check("tick_first", bus.frame_tick, 1);
    check("guard0", bus.LES, 4'hF);
    goto(33);
    check("tick_once", bus.frame_tick, 0);
    check("guard1", bus.LES, 4'hF);
    goto(34);
    check("unblanked", bus.LES, 4'h0);
    goto(40);
    ld(16'h1234, 4'b1010, 4'h0, 4'b0001);
    goto(66);
    check("blink_on_f2", bus.LES, 4'b0001);
    goto(98);
    check("blink_on_f3", bus.LES, 4'b0001);
    goto(130);
    check("blink_off_f4", bus.LES, 4'h0);
    goto(159);
    ld(16'hABCD, 4'h0, 4'b0100, 4'h0);
    check("boundary_load", bus.Hexs, 16'hABCD);
    check("boundary_guard", bus.LES, 4'hF);
    goto(162);
    check("boundary_les", bus.LES, 4'b0100);
    goto(193);
    check("no_stale", bus.Hexs, 16'hABCD);
    goto(200);
    ld(16'h1111, 4'h0, 4'h0, 4'h0);
    goto(210);
    ld(16'h2222, 4'h0, 4'h0, 4'h0);
    goto(223);
    check("two_loads_hold", bus.Hexs, 16'hABCD);
    goto(224);
    check("last_wins", bus.Hexs, 16'h2222);
    goto(240);
    ld(16'h5555, 4'hF, 4'h0, 4'h0);
    check("scan2_pre_rst", bus.Scan, 2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mid_rst_scan", bus.Scan, 0);
    check("mid_rst_les", bus.LES, 4'hF);
    check("mid_rst_hexs", bus.Hexs, 0);
    check("mid_rst_points", bus.Points, 0);
    goto(40);
    check("pending_discarded", bus.Hexs, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
